// File: rtl/jam_pkg.sv
// -----------------------------------------------------------------------------
// jam_pkg
// Shared types and constants for the cost-ROM arbiter slice.
//   idx_t        : 3-bit worker / job index
//   cost_t       : 7-bit cost word returned by the ROM
//   arb_state_e  : arbiter FSM state (IDLE, RUN, LOCK)
//   IDX_RST      : W/J address value held while in reset
//   burst_t      : saturating locked-grant counter
// -----------------------------------------------------------------------------
package jam_pkg;

    typedef logic [2:0] idx_t;
    typedef logic [6:0] cost_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOCK = 2'd2
    } arb_state_e;

    localparam idx_t IDX_RST = 3'd7;

    localparam int BURST_W = 7;
    typedef logic [BURST_W-1:0] burst_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic burst_t burst_sat_inc(input burst_t cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/jam_rr_pick.sv
// -----------------------------------------------------------------------------
// jam_rr_pick
// Combinational round-robin priority picker: grants the first active request
// found when scanning upward from ptr_i, wrapping past NREQ-1 back to 0.
//   req_i  : request vector
//   ptr_i  : index with highest priority this cycle
//   gnt_o  : one-hot grant (all zero when nothing is requested)
// -----------------------------------------------------------------------------
module jam_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic found;
    int   k;

    // NOTE: every variable written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr_i) + i) % NREQ;
            if (!found && req_i[k]) begin
                gnt_o[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jam_cost_arbiter.sv
// -----------------------------------------------------------------------------
// jam_cost_arbiter
// Shares one external cost ROM between NREQ job-assignment engines.
// Round-robin arbitration with an optional lock for burst matrix loads; the
// registered ROM address is driven on W/J and the returned cost is routed back
// with a one-hot rvalid tag LAT+2 cycles after the grant.
//   CLK, RST_N    : clock (rising edge), asynchronous active-low reset
//   req, lock     : per-requester read request / keep-ownership request
//   req_w, req_j  : per-requester worker/job index, slice k = bits 3k+2:3k
//   gnt           : one-hot combinational grant
//   W, J          : registered ROM address
//   Cost          : ROM data, valid LAT cycles after W/J change
//   rdata, rvalid : registered returned cost and its one-hot owner tag
//   owner_locked  : high while the arbiter is in LOCK
// -----------------------------------------------------------------------------
module jam_cost_arbiter
    import jam_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int LAT       = 0,
    parameter int BURST_MAX = 64
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     lock,
    input  logic [3*NREQ-1:0]   req_w,
    input  logic [3*NREQ-1:0]   req_j,
    output logic [NREQ-1:0]     gnt,
    output idx_t                W,
    output idx_t                J,
    input  cost_t               Cost,
    output cost_t               rdata,
    output logic [NREQ-1:0]     rvalid,
    output logic                owner_locked
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    typedef logic [PW-1:0] ptr_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_e      state_q;
    ptr_t            ptr_q;
    ptr_t            owner_q;
    burst_t          burst_q;
    idx_t            w_q, j_q;
    cost_t           rdata_q;
    logic [NREQ-1:0] rvalid_q;
    logic [NREQ-1:0] tag_q [LAT+1];

    logic [NREQ-1:0] rr_gnt;
    logic            gnt_any;
    ptr_t            gnt_idx;
    burst_t          burst_inc;

    function automatic ptr_t next_ptr(input ptr_t k);
        return (int'(k) >= NREQ - 1) ? '0 : ptr_t'(k + 1'b1);
    endfunction

    jam_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt)
    );

    // -------------------------------------------------------------------------
    // Grant: the round-robin pick, except in LOCK where only the owner may win.
    // An idle owner still blocks everybody else.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt = '0;
        if (state_q == LOCK) begin
            gnt[owner_q] = req[owner_q];
        end else begin
            gnt = rr_gnt;
        end
    end

    always_comb begin
        gnt_any = |gnt;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_idx = ptr_t'(k);
            end
        end
    end

    assign burst_inc = burst_sat_inc(burst_q);

    // -------------------------------------------------------------------------
    // Arbiter FSM. A release (lock drop or burst limit) only changes the
    // arbitration of the following cycle; the current grant always issues.
    // -------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, RUN: begin
                    if (gnt_any) begin
                        ptr_q <= next_ptr(gnt_idx);
                        if (lock[gnt_idx] && BURST_MAX > 1) begin
                            state_q <= LOCK;
                            owner_q <= gnt_idx;
                            burst_q <= burst_t'(1);
                        end else begin
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOCK: begin
                    if (gnt_any) begin
                        ptr_q <= next_ptr(owner_q);
                        // Burst limit forces a release even with lock held;
                        // the owner has to win through round-robin again.
                        if (!lock[owner_q] || int'(burst_inc) >= BURST_MAX) begin
                            state_q <= RUN;
                            burst_q <= '0;
                        end else begin
                            burst_q <= burst_inc;
                        end
                    end else if (!lock[owner_q]) begin
                        state_q <= IDLE;
                        burst_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Address register: holds the last granted address when nothing is granted.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_q <= IDX_RST;
            j_q <= IDX_RST;
        end else if (gnt_any) begin
            w_q <= req_w[3*int'(gnt_idx) +: 3];
            j_q <= req_j[3*int'(gnt_idx) +: 3];
        end
    end

    // -------------------------------------------------------------------------
    // Tag delay line: stage 0 captures the grant with the address, then LAT
    // more stages cover the ROM latency before the data is registered.
    // -------------------------------------------------------------------------
    // NOTE: this shift register is reset on purpose - grants in flight at
    // reset must never surface as rvalid afterwards.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s <= LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            tag_q[0] <= gnt;
            for (int s = 1; s <= LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= tag_q[LAT];
            if (|tag_q[LAT]) begin
                rdata_q <= Cost;
            end
        end
    end

    assign W            = w_q;
    assign J            = j_q;
    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign owner_locked = (state_q == LOCK);

    // At most one requester is granted and at most one return is tagged.
    assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(gnt));
    assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(rvalid));

endmodule

// File: doc/jam_cost_arbiter.md
Name: jam_cost_arbiter

Overview:
- Shares the single external cost ROM (W/J address out, 7-bit Cost in) between NREQ job-assignment engines.
- Each engine issues per-entry read requests over a req/gnt handshake.
- Round-robin arbitration with an optional lock for burst matrix loads; read data is routed back to the requester with a one-hot valid tag.
- Sits between the engines and the cost ROM port at the top level.

Parameters:
NREQ, 2, number of requesters (2..4)
LAT, 0, extra ROM read latency in cycles beyond combinational (0..3)
BURST_MAX, 64, max consecutive locked grants to one requester before a forced release

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
req  in  NREQ  per-requester read request
lock  in  NREQ  requester asks to keep ownership after this grant
req_w  in  3*NREQ  worker index per requester (slice k = bits 3k+2:3k)
req_j  in  3*NREQ  job index per requester
gnt  out  NREQ  one-hot combinational grant; request accepted this cycle
W  out  3  ROM worker address (registered)
J  out  3  ROM job address (registered)
Cost  in  7  ROM data for W/J, valid LAT cycles after W/J change
rdata  out  7  returned cost (registered, shared by all requesters)
rvalid  out  NREQ  one-hot; rdata belongs to this requester this cycle
owner_locked  out  1  high while FSM is in LOCK

Behaviour:
- Reset (async, RST_N=0): W=3'd7, J=3'd7, gnt=0, rvalid=0, rdata=0, owner_locked=0, RR pointer=0, burst count=0, FSM=IDLE, tag pipeline cleared.
- FSM states:
  - IDLE: no grant in the previous cycle.
  - RUN: granted last cycle, unlocked.
  - LOCK: owner holds the port.
- Arbitration in IDLE/RUN: grant the first requester with req=1, scanning from RR pointer upward with wrap. On grant k, RR pointer <= k+1 mod NREQ.
- Arbitration in LOCK: grant the owner whenever req[owner]=1. Other requesters get nothing, even if the owner is idle that cycle.
- Transitions:
  - Grant with lock[k]=1 -> LOCK, owner=k, burst count=1.
  - Grant without lock -> RUN.
  - No grant -> IDLE.
  - In LOCK, a grant to the owner with lock=0 -> RUN (this grant still issues).
  - In LOCK, owner req=0 and lock=0 -> IDLE.
  - In LOCK, burst count reaches BURST_MAX on a grant -> forced exit to RUN with RR pointer=owner+1, even if lock stays high. The owner may relock only via normal RR.
- Burst count: 7 bits, saturating, counts owner grants in LOCK.
- Pipeline, grant in cycle t:
  - Edge t+1: W/J <= req_w/req_j of grantee; tag stage0 <= gnt.
  - Tag shifts LAT stages.
  - Edge t+2+LAT: rdata <= Cost, rvalid <= tag.
  - rvalid is high for exactly one cycle per grant.
  - Request-to-rvalid latency = LAT+2 cycles.
  - Throughput: one grant per cycle, fully pipelined.
- W/J hold their last value when no grant occurs. The ROM data it produces is never tagged valid.
- req high without a grant: the requester must hold req/req_w/req_j stable until gnt. The arbiter keeps no request state.
- Simultaneous lock release and new request from another requester: the release takes effect after the current cycle. The other requester can win next cycle at earliest.
- Reset mid-operation: all in-flight tags are discarded. No rvalid is produced for requests granted before reset.
- At most one gnt bit and at most one rvalid bit are high in any cycle (assertion).

Decomposition:
- Package jam_pkg holds:
  - typedef idx_t (logic [2:0])
  - typedef cost_t (logic [6:0])
  - arb state enum {IDLE, RUN, LOCK}
  - constant IDX_RST = 3'd7
- One sub-module, jam_rr_pick: combinational round-robin priority picker (req vector + pointer -> one-hot grant).
- Tag delay line stays inline in jam_cost_arbiter.

Test Plan:
- Single requester: req[0]=1, W/J=(2,5) for one cycle, LAT=0 -> gnt[0] same cycle; W=2,J=5 next cycle; rvalid=2'b01 and rdata=ROM[2][5] two cycles after the request.
- Both requesting continuously, no lock -> gnt alternates 01,10,01,...; rvalid follows the same pattern delayed 2 cycles; each rdata matches its address.
- Requester 1 locks and sweeps 64 entries while req[0]=1 -> gnt[0]=0 for 64 grants; owner_locked=1 throughout; after the 64th grant, forced release and gnt[0]=1 next cycle.
- LAT=2 build, back-to-back grants (0,0),(0,1),(0,2) -> rvalid at cycles t+4, t+5, t+6 with the matching ROM values in order.
- RST_N pulsed low one cycle after two grants -> W=J=7, rvalid stays 0 for all pending requests, next req gets granted normally with RR pointer=0.
- Lock dropped on the same cycle as the owner's last request while req[0]=1 -> owner granted that cycle, requester 0 granted next cycle, FSM passes LOCK->RUN.
